// File: rtl/xoroshiro128plus_checker_pkg.sv
// Shared definitions for the xoroshiro128+ checker slice.
//   - xoro_state_t : the 128-bit generator state (s0, s1)
//   - xoro_step()  : one xoroshiro128+ state transition
//   - DEFAULT_SEED0/1 : seed pair the checker aligns to by default
//   - chk_state_t  : alignment state of the checker
package xoro_pkg;

    localparam logic [63:0] DEFAULT_SEED0 = 64'h1;
    localparam logic [63:0] DEFAULT_SEED1 = 64'h0;

    typedef struct packed {
        logic [63:0] s0;
        logic [63:0] s1;
    } xoro_state_t;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    function automatic xoro_state_t xoro_step(input logic [63:0] s0, input logic [63:0] s1);
        xoro_state_t nxt;
        logic [63:0] sx;
        sx     = s0 ^ s1;
        nxt.s0 = {s0[8:0], s0[63:9]} ^ sx ^ (sx << 14);
        nxt.s1 = {sx[27:0], sx[63:28]};
        return nxt;
    endfunction

endpackage

// File: rtl/xoroshiro128plus_checker_if.sv
// Word stream into the checker.
//   in_valid : source holds a word this cycle
//   in_data  : 64-bit received word
//   in_ready : checker accepts a word this cycle
// master = word source, slave = checker.
interface xoroshiro128plus_checker_if;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/xoroshiro128plus_checker_gen_en.sv
// Local xoroshiro128+ generator with advance and reload controls.
//   clk    : clock, rising edge
//   res    : synchronous active-high reset, loads the seed
//   adv    : advance the state by one step
//   reload : load the seed (wins over adv)
//   e      : current expected word s0 + s1, combinational from the state
module xoro_gen_en
    import xoro_pkg::*;
#(
    parameter logic [63:0] SEED0 = DEFAULT_SEED0,
    parameter logic [63:0] SEED1 = DEFAULT_SEED1
) (
    input  logic        clk,
    input  logic        res,
    input  logic        adv,
    input  logic        reload,
    output logic [63:0] e
);

    xoro_state_t st;

    always_ff @(posedge clk) begin
        if (res || reload) begin
            st.s0 <= SEED0;
            st.s1 <= SEED1;
        end else if (adv) begin
            st <= xoro_step(st.s0, st.s1);
        end
    end

    assign e = st.s0 + st.s1;

endmodule

// File: rtl/xoroshiro128plus_checker.sv
// Receive-side checker for a xoroshiro128+ test-pattern stream.
// Searches for the first sequence word, then compares every accepted word
// against a local generator, reporting lock, error pulses and counters.
//   clk        : clock, rising edge
//   res        : synchronous active-high reset
//   bus        : word stream (slave side); in_ready is low only in reset
//   locked     : aligned to the sequence
//   err_pulse  : one-cycle pulse per mismatching word while locked
//   err_count  : saturating count of mismatches while locked
//   word_count : saturating count of words checked while locked
module xoroshiro128plus_checker
    import xoro_pkg::*;
#(
    parameter logic [63:0] SEED0       = DEFAULT_SEED0,
    parameter logic [63:0] SEED1       = DEFAULT_SEED1,
    parameter int          LOSS_THRESH = 4,
    parameter int          CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 res,
    xoroshiro128plus_checker_if.slave bus,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     word_count
);

    localparam int MISS_W = $clog2(LOSS_THRESH + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    chk_state_t        state;
    logic [MISS_W-1:0] miss_run;
    logic [63:0]       expected;
    logic              accept;
    logic              match;
    logic              last_miss;
    logic              adv;
    logic              reload;

    assign bus.in_ready = !res;
    assign accept       = bus.in_valid && bus.in_ready;
    assign match        = (bus.in_data == expected);
    assign last_miss    = (miss_run == MISS_W'(LOSS_THRESH - 1));
    // In SEARCH only the seed word moves the generator; once locked every word does.
    assign adv          = accept && ((state == LOCKED) || match);
    // The word that exhausts the miss budget drops straight back to the seed.
    assign reload       = accept && (state == LOCKED) && !match && last_miss;
    assign locked       = (state == LOCKED);

    xoro_gen_en #(
        .SEED0 (SEED0),
        .SEED1 (SEED1)
    ) u_gen (
        .clk    (clk),
        .res    (res),
        .adv    (adv),
        .reload (reload),
        .e      (expected)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            state      <= SEARCH;
            miss_run   <= '0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            word_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (accept) begin
                case (state)
                    SEARCH: begin
                        if (match) begin
                            state      <= LOCKED;
                            word_count <= sat_inc(word_count);
                        end
                    end
                    LOCKED: begin
                        word_count <= sat_inc(word_count);
                        if (match) begin
                            miss_run <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            err_count <= sat_inc(err_count);
                            if (last_miss) begin
                                miss_run <= '0;
                                state    <= SEARCH;
                            end else begin
                                miss_run <= miss_run + MISS_W'(1);
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: doc/xoroshiro128plus_checker.md
# xoroshiro128plus_checker

Receive-side companion to the xoroshiro128+ generator. It consumes a stream of 64-bit words, aligns to the start of the xoroshiro128+ sequence, and checks each subsequent word against a local copy of the generator. It reports lock status, per-word error pulses and saturating counters. It sits at the far end of a link, FIFO or memory path under test, wherever the generator's output is used as a test pattern.

## Interface
- SEED0, 64'h1: initial s0 of the expected sequence.
- SEED1, 64'h0: initial s1 of the expected sequence.
- LOSS_THRESH, 4: consecutive mismatches that drop lock (≥1).
- CNT_W, 32: width of the counters.

- clk  in  1  clock; all logic is on the rising edge.
- res  in  1  synchronous active-high reset.
- in_valid  in  1  in_data holds a word this cycle.
- in_data  in  64  received word.
- in_ready  out  1  checker accepts a word this cycle.
- locked  out  1  checker is aligned to the sequence.
- err_pulse  out  1  one-cycle pulse: the last accepted word mismatched while locked.
- err_count  out  CNT_W  mismatches while locked; saturating.
- word_count  out  CNT_W  words checked while locked (includes the lock word); saturating.

## Operation
- Expected sequence:
  - E[k] = s0_k + s1_k mod 2^64, with (s0_0, s1_0) = (SEED0, SEED1).
  - step: sx = s0^s1; s0' = rotr(s0,9) ^ sx ^ (sx<<14); s1' = rotr(sx,28).
  - For the default seeds, E[0] = 64'h1 and E[1] = 64'h0080_0010_0000_4001.
- A word is accepted when in_valid && in_ready. in_ready is 0 during reset and 1 at all other times; the checker never stalls.
- States:
  - SEARCH (reset state): local state = seed.
    - Accepted word == E[0]: advance to state 1, go to LOCKED, word_count += 1.
    - Accepted word != E[0]: ignored. No error, no count.
  - LOCKED: each accepted word is compared with E[k], and the local state always advances by exactly one step.
    - Match: miss_run := 0, word_count += 1.
    - Mismatch: err_pulse, err_count += 1, word_count += 1, miss_run += 1.
    - miss_run reaching LOSS_THRESH: reload the seed, miss_run := 0, go to SEARCH. The word that triggers the loss is not re-tested against E[0].
- Cycles without an accepted word change nothing. The state does not advance.
- Counters saturate at all-ones and never wrap.
- Reset values: locked=0, err_pulse=0, err_count=0, word_count=0, miss_run=0, state=SEARCH, local state = seed.
- res asserted mid-operation: all of the above on the next edge, and any in-flight word is discarded.

## Timing
- A word accepted at edge t updates locked, err_pulse and the counters, all registered, visible after edge t.
- Latency is 1 cycle.
- Back-to-back words (in_valid held high) are checked at full rate, one per cycle.
- err_pulse is high for exactly one cycle per mismatching word.
- The SEARCH→LOCKED and LOCKED→SEARCH transitions are visible on locked in the same cycle as the corresponding counter update.

## Structure
- Shared package xoro_pkg holds:
  - the function xoro_step(s0, s1) returning the next state;
  - the default seed constants;
  - the state enum {SEARCH, LOCKED}.
- Natural sub-module: xoro_gen_en.
  - Ports: clk, res, adv, reload.
  - Outputs: the current E[k] combinationally from the state registers.
  - Reload has priority over adv.
  - The checker instantiates one.

## Test plan
- Lock from the generator: drive generator output directly, with its first word 0 → 0 is ignored. Word 64'h1 → locked=1 next cycle. Next word 64'h0080_0010_0000_4001 matches. After 1000 words: err_count=0, word_count=1000.
- Single-bit error: flip bit 0 of word 10 while locked → err_pulse high one cycle, err_count=1, locked stays 1, word 11 matches.
- Loss and relock: LOSS_THRESH=4, four consecutive wrong words → err_count=4, locked=0 after the 4th. Then feed 64'h1 → locked=1 and the next check expects E[1].
- Gapped stream: in_valid toggled pseudo-randomly over 500 generator words → no errors, word_count=500. State advances only on accepted words.
- Reset mid-lock: assert res for 1 cycle after 50 words → all outputs 0, SEARCH. Resumed sequence mid-stream → stays unlocked until 64'h1 appears.
- Saturation: CNT_W=4, 20 mismatching words with LOSS_THRESH=32 → err_count holds 4'hF and does not wrap.
